// File: rtl/r2sdf_bitrev_reorder_if.sv
// rtl/r2sdf_bitrev_reorder_if.sv - shared complex sample type and reorder stream interface
// Optional feature macro: R2SDF_REORDER_ERR_EN (adds err_resync)
package R2SdfDefinesPkg;
  localparam int DW = 16;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } Cplx;
endpackage

interface r2sdf_bitrev_reorder_if;
  import R2SdfDefinesPkg::*;
  logic en;
  Cplx  in;
  logic in_sync;
  Cplx  out;
  logic out_sync;
  logic out_valid;
`ifdef R2SDF_REORDER_ERR_EN
  logic err_resync;
  modport master (output en, in, in_sync, input out, out_sync, out_valid, err_resync);
  modport slave  (input en, in, in_sync, output out, out_sync, out_valid, err_resync);
`else
  modport master (output en, in, in_sync, input out, out_sync, out_valid);
  modport slave  (input en, in, in_sync, output out, out_sync, out_valid);
`endif
endinterface

// File: rtl/r2sdf_bitrev_reorder.sv
// rtl/r2sdf_bitrev_reorder.sv - ping-pong bit-reversed to natural order frame reorder
// Optional feature macro: R2SDF_REORDER_ERR_EN (sticky mid-frame resync flag)
module r2sdf_bitrev_reorder
  import R2SdfDefinesPkg::*;
#(
  parameter int STG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  r2sdf_bitrev_reorder_if.slave io
);

  localparam int N = 1 << STG;

  typedef enum logic {IDLE, STREAM} rd_state_t;

  function automatic logic [STG-1:0] bitrev(input logic [STG-1:0] a);
    logic [STG-1:0] r;
    for (int i = 0; i < STG; i++) r[i] = a[STG-1-i];
    return r;
  endfunction

  Cplx            mem [2*N];
  logic [STG-1:0] wcnt, widx, waddr;
  logic           armed, wbank, wr_en, wr_done;
  logic [1:0]     full;
  rd_state_t      state, state_nxt;
  logic [STG-1:0] rcnt, rcnt_nxt;
  logic           rbank, rbank_nxt, rd_en, rd_last;
  Cplx            rd_q;
  logic           rd_valid, rd_sync;

  // Write side: in_sync forces index 0, otherwise the free-running index is used once armed
  always_comb begin
    widx    = io.in_sync ? '0 : wcnt;
    wr_en   = io.in_sync | armed;
    wr_done = wr_en && (widx == '1);
    waddr   = bitrev(widx);
  end

  // Write counter, arming and bank selection; a mid-frame sync just restarts the same bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      armed <= 1'b0;
      wbank <= 1'b0;
    end else if (io.en && wr_en) begin
      wcnt  <= widx + STG'(1);
      armed <= 1'b1;
      if (wr_done) wbank <= ~wbank;
    end
  end

  // Bank full flags: set on frame completion, cleared when the reader takes the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else if (io.en) begin
      if (rd_last) full[rbank] <= 1'b0;
      if (wr_done) full[wbank] <= 1'b1;
    end
  end

  // Read FSM: stream natural order; at the last word continue if the other bank is (or is just becoming) full
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    rd_en     = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          state_nxt = STREAM;
          rcnt_nxt  = '0;
        end
      end
      STREAM: begin
        rd_en    = 1'b1;
        rcnt_nxt = rcnt + STG'(1);
        if (rcnt == '1) begin
          rd_last   = 1'b1;
          rbank_nxt = ~rbank;
          if (!(full[~rbank] || (wr_done && (wbank != rbank)))) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else if (io.en) begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rbank <= rbank_nxt;
    end
  end

  // Two-bank sample RAM with registered read port; contents are never reset
  always_ff @(posedge clk) begin
    if (io.en) begin
      if (wr_en) mem[{wbank, waddr}] <= io.in;
      if (rd_en) rd_q <= mem[{rbank, rcnt}];
    end
  end

  // Read pipeline flags aligned with the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_sync  <= 1'b0;
    end else if (io.en) begin
      rd_valid <= rd_en;
      rd_sync  <= rd_en && (rcnt == '0);
    end
  end

  // Output register; out holds its last sample while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out       <= '0;
      io.out_valid <= 1'b0;
      io.out_sync  <= 1'b0;
    end else if (io.en) begin
      io.out_valid <= rd_valid;
      io.out_sync  <= rd_sync;
      if (rd_valid) io.out <= rd_q;
    end
  end

`ifdef R2SDF_REORDER_ERR_EN
  logic resync;
  assign resync = io.in_sync & armed & (wcnt != '0);

  // Sticky flag for a sync arriving part-way through a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) io.err_resync <= 1'b0;
    else if (io.en && resync) io.err_resync <= 1'b1;
  end
`else
  // Mid-frame resync needs no extra state: the writer restarts at sample 0 by itself.
`endif

endmodule

// File: tb/tb_r2sdf_bitrev_reorder.sv
// tb/tb_r2sdf_bitrev_reorder.sv - self-checking bench for r2sdf_bitrev_reorder
module tb_r2sdf_bitrev_reorder;
  import R2SdfDefinesPkg::*;

  localparam int STG = 4;
  localparam int N   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  r2sdf_bitrev_reorder_if io ();
  r2sdf_bitrev_reorder #(.STG(STG)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  int checks = 0;
  int errors = 0;
  int ecyc;

  // Reference model: frames stored by natural index, output schedule from timing rules
  Cplx  exp_d [int];
  bit   exp_s [int];
  Cplx  obs_d [int];
  logic obs_v [int];
  logic obs_s [int];
  Cplx  frm [N];
  bit   m_armed;
  int   m_idx;
  int   last_start;
  bit   have_prev;
`ifdef R2SDF_REORDER_ERR_EN
  bit   m_err;
`endif

  function automatic int brev(int k);
    int r = 0;
    for (int b = 0; b < STG; b++) if ((k >> b) & 1) r |= 1 << (STG - 1 - b);
    return r;
  endfunction

  function automatic Cplx pat(int k);
    Cplx d;
    d.re = 16'(brev(k));
    d.im = 16'(100 + brev(k));
    return d;
  endfunction

  task automatic model_reset();
    exp_d.delete(); exp_s.delete();
    obs_d.delete(); obs_v.delete(); obs_s.delete();
    ecyc = 0; m_armed = 0; m_idx = 0; have_prev = 0; last_start = 0;
`ifdef R2SDF_REORDER_ERR_EN
    m_err = 0;
`endif
  endtask

  task automatic model_in(input bit s, input Cplx d);
    int k, start;
    if (s) begin
`ifdef R2SDF_REORDER_ERR_EN
      if (m_armed && m_idx != 0) m_err = 1;
`endif
      k = 0;
      m_armed = 1;
    end else if (m_armed) begin
      k = m_idx;
    end else begin
      return;
    end
    frm[brev(k)] = d;
    m_idx = (k + 1) % N;
    if (k == N - 1) begin
      start = (have_prev && ecyc <= last_start + 14) ? last_start + 16 : ecyc + 3;
      for (int j = 0; j < N; j++) begin
        exp_d[start + j] = frm[j];
        exp_s[start + j] = (j == 0);
      end
      last_start = start;
      have_prev  = 1;
    end
  endtask

  // One enabled cycle: drive, advance the model, record outputs after the edge
  task automatic step(input bit s, input Cplx d);
    io.en = 1'b1; io.in_sync = s; io.in = d;
    model_in(s, d);
    @(posedge clk); #1;
    obs_v[ecyc] = io.out_valid;
    obs_s[ecyc] = io.out_sync;
    obs_d[ecyc] = io.out;
    ecyc++;
  endtask

  task automatic do_reset();
    io.en = 1'b0; io.in_sync = 1'b0; io.in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io.en = 1'b1; io.in_sync = 1'b1; io.in = $urandom;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (io.out !== '0) begin errors++; $display("FAIL reset_out got %h want 0", io.out); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", io.out_valid); end
    checks++; if (io.out_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %b want 0", io.out_sync); end
`ifdef R2SDF_REORDER_ERR_EN
    checks++; if (io.err_resync !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", io.err_resync); end
`endif
    do_reset();
  endtask

  task automatic test_single();
    Cplx hold = '0;
    do_reset();
    for (int i = 0; i < 41; i++) step(i == 0 || i >= N, (i < N) ? pat(i) : Cplx'($urandom));
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL single c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL single c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
    end
    checks++;
    if (obs_d[18].re !== 16'sd0 || obs_d[18].im !== 16'sd100 || obs_s[18] !== 1'b1)
      begin errors++; $display("FAIL single_first got %h s=%b want 00000064 s=1", obs_d[18], obs_s[18]); end
    checks++;
    if (obs_v[33] !== 1'b1 || obs_v[34] !== 1'b0)
      begin errors++; $display("FAIL single_drop got v33=%b v34=%b want 1 0", obs_v[33], obs_v[34]); end
  endtask

  task automatic test_back_to_back();
    Cplx hold = '0;
    int nv = 0;
    do_reset();
    for (int i = 0; i < 68; i++) step(i == 0 || i >= 3 * N, Cplx'($urandom));
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL b2b c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL b2b c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
      if (obs_v[c] === 1'b1) nv++;
    end
    checks++;
    if (nv != 48) begin errors++; $display("FAIL b2b_count got %0d want 48", nv); end
    checks++;
    if (obs_s[18] !== 1'b1 || obs_s[34] !== 1'b1 || obs_s[50] !== 1'b1)
      begin errors++; $display("FAIL b2b_sync got %b%b%b want 111", obs_s[18], obs_s[34], obs_s[50]); end
  endtask

  task automatic test_en_toggle();
    Cplx hold = '0;
    Cplx snap;
    logic sv, ss;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      step(i == 0 || i >= N, (i < N) ? pat(i) : Cplx'($urandom));
      snap = io.out; sv = io.out_valid; ss = io.out_sync;
      io.en = 1'b0; io.in_sync = 1'($urandom); io.in = $urandom;
      @(posedge clk); #1;
      checks++;
      if (io.out !== snap || io.out_valid !== sv || io.out_sync !== ss) begin
        errors++; $display("FAIL en_freeze i=%0d got v=%b s=%b d=%h want v=%b s=%b d=%h", i, io.out_valid, io.out_sync, io.out, sv, ss, snap);
      end
    end
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL en_toggle c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL en_toggle c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
    end
    checks++;
    if (obs_s[18] !== 1'b1) begin errors++; $display("FAIL en_latency got s18=%b want 1", obs_s[18]); end
  endtask

  task automatic test_resync();
    Cplx hold = '0;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, Cplx'($urandom));
    for (int i = 0; i < 7; i++) step(i == 0, Cplx'($urandom));
`ifdef R2SDF_REORDER_ERR_EN
    checks++; if (io.err_resync !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", io.err_resync); end
`endif
    step(1'b1, pat(0));
`ifdef R2SDF_REORDER_ERR_EN
    checks++; if (io.err_resync !== 1'b1) begin errors++; $display("FAIL err_after got %b want 1", io.err_resync); end
    checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL err_model got %b want 1", m_err); end
`endif
    for (int i = 1; i < N; i++) step(1'b0, pat(i));
    for (int i = 0; i < 22; i++) step(1'b1, Cplx'($urandom));
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL resync c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL resync c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
    end
    checks++;
    if (obs_v[29] !== 1'b0 || obs_s[30] !== 1'b1 || obs_d[30].im !== 16'sd100)
      begin errors++; $display("FAIL resync_first got v29=%b s30=%b d=%h want 0 1 im=100", obs_v[29], obs_s[30], obs_d[30]); end
  endtask

  task automatic test_reset_mid();
    Cplx hold = '0;
    do_reset();
    for (int i = 0; i < 25; i++) step(i == 0 || i >= N, Cplx'($urandom));
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL rst_pre c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL rst_pre c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
    end
    checks++;
    if (obs_v[24] !== 1'b1) begin errors++; $display("FAIL rst_mid_active got %b want 1", obs_v[24]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io.out !== '0 || io.out_valid !== 1'b0 || io.out_sync !== 1'b0)
      begin errors++; $display("FAIL rst_async got v=%b s=%b d=%h want 0 0 0", io.out_valid, io.out_sync, io.out); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    hold = '0;
    for (int i = 0; i < 10; i++) step(1'b0, Cplx'($urandom));
    for (int i = 0; i < N; i++) step(i == 0, Cplx'($urandom));
    for (int i = 0; i < 22; i++) step(1'b1, Cplx'($urandom));
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL rst_post c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL rst_post c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
    end
    checks++;
    if (obs_s[28] !== 1'b1) begin errors++; $display("FAIL rst_resume got s28=%b want 1", obs_s[28]); end
  endtask

  task automatic test_seamless_wrap();
    Cplx hold = '0;
    int nv = 0;
    do_reset();
    for (int i = 0; i < N; i++) step(i == 0, Cplx'($urandom));
    step(1'b0, Cplx'($urandom));
    for (int i = 0; i < N; i++) step(i == 0, Cplx'($urandom));
    for (int i = 0; i < 22; i++) step(1'b1, Cplx'($urandom));
    for (int c = 0; c < ecyc; c++) begin
      checks++;
      if (exp_d.exists(c)) begin
        if (obs_v[c] !== 1'b1 || obs_s[c] !== exp_s[c] || obs_d[c] !== exp_d[c]) begin
          errors++; $display("FAIL wrap c=%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", c, obs_v[c], obs_s[c], obs_d[c], exp_s[c], exp_d[c]);
        end
        hold = exp_d[c];
      end else if (obs_v[c] !== 1'b0 || obs_s[c] !== 1'b0 || obs_d[c] !== hold) begin
        errors++; $display("FAIL wrap c=%0d got v=%b s=%b d=%h want v=0 s=0 d=%h", c, obs_v[c], obs_s[c], obs_d[c], hold);
      end
    end
    for (int c = 18; c < 50; c++) if (obs_v[c] === 1'b1) nv++;
    checks++;
    if (nv != 32 || obs_s[34] !== 1'b1 || obs_v[50] !== 1'b0)
      begin errors++; $display("FAIL wrap_gapless got n=%0d s34=%b v50=%b want 32 1 0", nv, obs_s[34], obs_v[50]); end
  endtask

  initial begin
    io.en = 1'b0; io.in_sync = 1'b0; io.in = '0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_en_toggle();
    test_resync();
    test_reset_mid();
    test_seamless_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
